tick_divider_bank: RTL

Parametrised multi-channel tick generator clocked from the 1 ms system tick. It replaces the single fixed /10 divider with CHANNELS independent dividers. Each channel has a runtime-loadable divisor, an enable, and a periodic or one-shot mode. It feeds game-timing consumers (scroll speed, obstacle spawn, score timer, animation) with single-cycle tick pulses.

---
 rtl/tick_pkg.sv | 20 ++
 rtl/tick_divider_bank_channel.sv | 75 +++++++
 rtl/tick_divider_bank.sv | 59 +++++
 3 files changed

// File: rtl/tick_pkg.sv
// Shared constants, types and the effective-divisor helper for the tick divider bank.
package tick_pkg;

  localparam int unsigned DEFAULT_DIV_C = 10;
  localparam int unsigned MAX_CHANNELS  = 16;
  localparam int unsigned TICK_WIDTH    = 10;

  typedef logic [TICK_WIDTH-1:0] tick_div_t;

  typedef enum logic {
    MODE_PERIODIC = 1'b0,
    MODE_ONESHOT  = 1'b1
  } tick_mode_e;

  // Divisors of 0 and 1 both mean "tick every cycle".
  function automatic logic [31:0] deff_f(input logic [31:0] div);
    return (div <= 32'd1) ? 32'd1 : div;
  endfunction

endpackage

// File: rtl/tick_divider_bank_channel.sv
// One divider slice: counter, runtime divisor and one-shot arm flag.
module tick_channel
  import tick_pkg::*;
#(
  parameter int unsigned WIDTH       = TICK_WIDTH,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_C
) (
  input  logic             clk_1ms,
  input  logic             reset,
  input  logic             en,
  input  logic             oneshot,
  input  logic             load_hit,
  input  logic [WIDTH-1:0] load_div,
  input  logic             freeze,
  output logic             tick,
  output logic             busy
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic             armed_q, armed_d;
  logic             tick_q, tick_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] term;
  tick_mode_e       mode;

  assign mode = tick_mode_e'(oneshot);
  assign term = WIDTH'(deff_f(32'(div_q))) - WIDTH'(1);

  // Priority: load, then freeze, then disable, then counting.
  always_comb begin
    cnt_d   = cnt_q;
    div_d   = div_q;
    armed_d = armed_q;
    tick_d  = 1'b0;
    if (load_hit) begin
      div_d = load_div;
      cnt_d = '0;
    end else if (freeze) begin
      cnt_d = cnt_q;
    end else if (!en) begin
      cnt_d   = '0;
      armed_d = 1'b1;
    end else if (mode == MODE_ONESHOT && !armed_q) begin
      cnt_d = '0;
    end else if (cnt_q == term) begin
      cnt_d  = '0;
      tick_d = 1'b1;
      if (mode == MODE_ONESHOT) armed_d = 1'b0;
    end else begin
      cnt_d = cnt_q + WIDTH'(1);
    end
    busy_d = en & armed_d & ~freeze;
  end

  always_ff @(posedge clk_1ms) begin
    if (reset) begin
      cnt_q   <= '0;
      div_q   <= WIDTH'(DEFAULT_DIV);
      armed_q <= 1'b1;
      tick_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      armed_q <= armed_d;
      tick_q  <= tick_d;
      busy_q  <= busy_d;
    end
  end

  assign tick = tick_q;
  assign busy = busy_q;

endmodule

// File: rtl/tick_divider_bank.sv
// Bank of CHANNELS independent tick dividers on the 1 ms tick.
// Optional global freeze on `pause` when DIVIDER_PAUSE_EN is defined.
module tick_divider_bank
  import tick_pkg::*;
#(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned WIDTH       = TICK_WIDTH,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_C,
  localparam int unsigned SELW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk_1ms,
  input  logic                reset,
  input  logic [CHANNELS-1:0] en,
  input  logic [CHANNELS-1:0] oneshot,
  input  logic                load,
  input  logic [SELW-1:0]     load_sel,
  input  logic [WIDTH-1:0]    load_div,
  input  logic                pause,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] busy
);

  logic                freeze;
  logic [CHANNELS-1:0] load_hit;

`ifdef DIVIDER_PAUSE_EN
  assign freeze = pause;
`else
  logic unused_pause;
  assign unused_pause = pause;
  assign freeze       = 1'b0;
`endif

  // Out-of-range selects match no slice, so such loads are dropped.
  always_comb begin
    load_hit = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      load_hit[i] = load && (32'(load_sel) == i);
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    tick_channel #(
      .WIDTH      (WIDTH),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_ch (
      .clk_1ms (clk_1ms),
      .reset   (reset),
      .en      (en[g]),
      .oneshot (oneshot[g]),
      .load_hit(load_hit[g]),
      .load_div(load_div),
      .freeze  (freeze),
      .tick    (tick[g]),
      .busy    (busy[g])
    );
  end

endmodule
